norm_seq: RTL
=============

NORM_SEQ -- requirements
Module: norm_seq

Interface
REQ-001 SHALL have parameter: STEP, 1, maximum left-shift bits per NORM cycle (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  operand present.
REQ-005 SHALL have port: in_ready  out  1  block accepts operand.
REQ-006 SHALL have port: exp_in  in  8  biased exponent of the larger operand.
REQ-007 SHALL have port: frac_in  in  25  unnormalized sum; bit24 = carry, bit23 = hidden-bit position.
REQ-008 SHALL have port: out_valid  out  1  result present.
REQ-009 SHALL have port: out_ready  in  1  consumer accepts result.
REQ-010 SHALL have port: exp_out  out  8  biased result exponent.
REQ-011 SHALL have port: frac_out  out  23  result fraction, hidden bit removed.
REQ-012 SHALL have port: zero_out, ovf_out, uflow_out  out  1 each  result flags.
REQ-013 SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CHECK, NORM, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE with rst low.
- Accept on in_valid & in_ready; register exp_in/frac_in; go to CHECK.
REQ-016 SHALL treat exp_in=0 as exponent 1 (denormal encoding) for all arithmetic.
REQ-017 SHALL, in CHECK, resolve in priority order:
- frac==0 -> exp_out=0, frac_out=0, zero_out=1, go to DONE.
- frac[24]=1 -> exp+1, frac_out=frac[23:1] (truncate); if exp+1>=255 then exp_out=255, frac_out=0, ovf_out=1; go to DONE.
- frac[23]=1 -> exp_out=exp, frac_out=frac[22:0], go to DONE.
- exp==1 -> exp_out=0, frac_out=frac[22:0], uflow_out=1, go to DONE.
- otherwise go to NORM.
REQ-018 SHALL, each NORM cycle, shift left by s = min(STEP, leading zeros above bit23, exp-1) and decrement exp by s.
REQ-019 SHALL leave NORM for DONE when the shifted frac[23]=1 (exp_out=exp) or exp reaches 1 with frac[23]=0 (exp_out=0, uflow_out=1).
- frac_out = shifted frac[22:0] in both cases.
REQ-020 SHALL, in DONE, hold out_valid=1 and all outputs stable until out_ready=1, then return to IDLE.
REQ-021 SHALL give latency: accept at edge k -> out_valid from cycle k+2 when no NORM is needed; k+2+ceil(lz/STEP) otherwise (when not exp-limited).
REQ-022 SHALL accept no new operand while busy; accept-to-accept minimum is 3 cycles (in_ready returns the cycle after the out handshake).
REQ-023 SHALL register all outputs; flags not set for a result SHALL be 0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE, discard any operation in flight, and clear all registered outputs and flags to 0.
REQ-025 SHALL hold in_ready=0 while rst=1 and raise it in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with NORM_SEQ_STATS_EN defined, add port op_count  out  16, incremented on each out handshake, wrapping 0xFFFF->0, reset to 0.
- Without the macro the port and counter SHALL be absent; behaviour is otherwise identical.

Verification
REQ-027 SHALL cover: exp_in=0x80, frac_in=0x0800000 -> out_valid at accept+2, exp_out=0x80, frac_out=0, no flags.
REQ-028 SHALL cover: exp_in=0x80, frac_in=0x1800000 -> exp_out=0x81, frac_out=0x400000.
REQ-029 SHALL cover: STEP=1, exp_in=0x80, frac_in=0x0000001 -> 23 NORM cycles, out_valid at accept+25, exp_out=0x69, frac_out=0.
REQ-030 SHALL cover: exp_in=0x03, frac_in=0x0100000 -> exp_out=0, frac_out=0x400000, uflow_out=1.
REQ-031 SHALL cover: exp_in=0xFE, frac_in=0x1000000 -> exp_out=0xFF, frac_out=0, ovf_out=1.
REQ-032 SHALL cover two cases:
- out_ready low 5 cycles in DONE -> outputs stable, in_ready=0.
- rst pulsed mid-NORM -> out_valid=0 and in_ready=1 in the cycle after rst falls; op_count unchanged.

Source files
------------

// File: rtl/norm_seq.sv
// norm_seq: multi-cycle normaliser for an unnormalised 25-bit mantissa sum, shifting up to STEP bits per cycle.
// Define NORM_SEQ_STATS_EN to add op_count, a 16-bit wrapping count of completed results.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CHECK | classify captured operand: zero / carry-out / already normal / underflow / needs shifting
// NORM  | left-shift by min(STEP, leading zeros, exp-1) per cycle
// DONE  | result held with out_valid until out_ready
module norm_seq #(
   parameter int unsigned STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  exp_in,
   input  logic [24:0] frac_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  exp_out,
   output logic [22:0] frac_out,
   output logic        zero_out,
   output logic        ovf_out,
   output logic        uflow_out,
   output logic        busy
`ifdef NORM_SEQ_STATS_EN
   ,
   output logic [15:0] op_count
`endif
);

   typedef enum logic [1:0] {IDLE, CHECK, NORM, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  exp_q, exp_d;
   logic [24:0] frac_q, frac_d;
   logic        out_valid_d, zero_d, ovf_d, uflow_d;
   logic [7:0]  exp_out_d;
   logic [22:0] frac_out_d;
   logic [4:0]  lz;
   logic [7:0]  shamt;
   logic [7:0]  exp_sh;
   logic [24:0] frac_sh;
   logic [8:0]  exp_inc;

   assign in_ready = (state_q == IDLE) && !rst;
   assign exp_inc  = {1'b0, exp_q} + 9'd1;

   // Leading zeros above the hidden-bit position; the highest set bit wins.
   always_comb begin
      lz = 5'd24;
      for (int i = 0; i <= 23; i++) begin
         if (frac_q[i]) lz = 5'(23 - i);
      end
   end

   // exp_q is never 0 (a zero exponent is captured as 1), so exp_q-1 cannot wrap.
   always_comb begin
      shamt = 8'(STEP);
      if ({3'b000, lz} < shamt) shamt = {3'b000, lz};
      if ((exp_q - 8'd1) < shamt) shamt = exp_q - 8'd1;
      frac_sh = frac_q << shamt;
      exp_sh  = exp_q - shamt;
   end

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      frac_d      = frac_q;
      out_valid_d = out_valid;
      exp_out_d   = exp_out;
      frac_out_d  = frac_out;
      zero_d      = zero_out;
      ovf_d       = ovf_out;
      uflow_d     = uflow_out;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CHECK;
               exp_d   = (exp_in == 8'd0) ? 8'd1 : exp_in;
               frac_d  = frac_in;
            end
         end
         CHECK: begin
            if (frac_q == 25'd0) begin
               state_d = DONE; out_valid_d = 1'b1;
               exp_out_d = 8'd0; frac_out_d = 23'd0;
               zero_d = 1'b1; ovf_d = 1'b0; uflow_d = 1'b0;
            end else if (frac_q[24]) begin
               state_d = DONE; out_valid_d = 1'b1;
               zero_d = 1'b0; uflow_d = 1'b0;
               if (exp_inc >= 9'd255) begin
                  exp_out_d = 8'hFF; frac_out_d = 23'd0; ovf_d = 1'b1;
               end else begin
                  exp_out_d = exp_inc[7:0]; frac_out_d = frac_q[23:1]; ovf_d = 1'b0;
               end
            end else if (frac_q[23]) begin
               state_d = DONE; out_valid_d = 1'b1;
               exp_out_d = exp_q; frac_out_d = frac_q[22:0];
               zero_d = 1'b0; ovf_d = 1'b0; uflow_d = 1'b0;
            end else if (exp_q == 8'd1) begin
               state_d = DONE; out_valid_d = 1'b1;
               exp_out_d = 8'd0; frac_out_d = frac_q[22:0];
               zero_d = 1'b0; ovf_d = 1'b0; uflow_d = 1'b1;
            end else begin
               state_d = NORM;
            end
         end
         NORM: begin
            exp_d  = exp_sh;
            frac_d = frac_sh;
            // Exit is judged on the freshly shifted value, so no extra cycle is spent.
            if (frac_sh[23]) begin
               state_d = DONE; out_valid_d = 1'b1;
               exp_out_d = exp_sh; frac_out_d = frac_sh[22:0];
               zero_d = 1'b0; ovf_d = 1'b0; uflow_d = 1'b0;
            end else if (exp_sh == 8'd1) begin
               state_d = DONE; out_valid_d = 1'b1;
               exp_out_d = 8'd0; frac_out_d = frac_sh[22:0];
               zero_d = 1'b0; ovf_d = 1'b0; uflow_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         exp_q     <= 8'd0;
         frac_q    <= 25'd0;
         out_valid <= 1'b0;
         exp_out   <= 8'd0;
         frac_out  <= 23'd0;
         zero_out  <= 1'b0;
         ovf_out   <= 1'b0;
         uflow_out <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         frac_q    <= frac_d;
         out_valid <= out_valid_d;
         exp_out   <= exp_out_d;
         frac_out  <= frac_out_d;
         zero_out  <= zero_d;
         ovf_out   <= ovf_d;
         uflow_out <= uflow_d;
         busy      <= (state_d != IDLE);
      end
   end

`ifdef NORM_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         op_count <= 16'd0;
      else if (state_q == DONE && out_ready)
         op_count <= op_count + 16'd1;
   end
`endif

endmodule
